// File: rtl/multi_sad_comparator_if.sv
// Beat/result bundle for multi_sad_comparator.
// The master drives candidate beats and control; the slave is the comparator itself.
interface multi_sad_comparator_if #(
    parameter int SAD_W = 16,
    parameter int MV_W  = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 12
);
    logic                   start;
    logic                   in_valid;
    logic                   in_last;
    logic [LANES-1:0]       lane_mask;
    logic [LANES*SAD_W-1:0] sad_i;
    logic [LANES*MV_W-1:0]  mv_x_i;
    logic [LANES*MV_W-1:0]  mv_y_i;
    logic [SAD_W-1:0]       thresh;
    logic [SAD_W-1:0]       min_sad;
    logic [MV_W-1:0]        mv_x;
    logic [MV_W-1:0]        mv_y;
    logic                   best_valid;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   busy;
    logic                   done;
    logic                   early_hit;

    modport master (
        output start, in_valid, in_last, lane_mask, sad_i, mv_x_i, mv_y_i, thresh,
        input  min_sad, mv_x, mv_y, best_valid, beat_cnt, busy, done, early_hit
    );

    modport slave (
        input  start, in_valid, in_last, lane_mask, sad_i, mv_x_i, mv_y_i, thresh,
        output min_sad, mv_x, mv_y, best_valid, beat_cnt, busy, done, early_hit
    );
endinterface

// File: rtl/multi_sad_comparator.sv
// Multi-lane SAD minimum search: input register, registered lane min-tree, running minimum.
// Optional threshold early termination is enabled by defining SAD_EARLY_TERM_EN.
module multi_sad_comparator #(
    parameter int SAD_W = 16,
    parameter int MV_W  = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_sad_comparator_if.slave bus
);
    localparam int NP    = 1 << $clog2(LANES);
    localparam int NODES = 2 * NP - 1;
    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
    state_t state_reg, state_next;

    logic                   s0_valid_reg, s0_last_reg;
    logic [LANES-1:0]       s0_mask_reg;
    logic [LANES*SAD_W-1:0] s0_sad_reg;
    logic [LANES*MV_W-1:0]  s0_mvx_reg, s0_mvy_reg;

    logic                   s1_valid_reg, s1_last_reg, s1_any_reg;
    logic [SAD_W-1:0]       s1_sad_reg;
    logic [MV_W-1:0]        s1_mvx_reg, s1_mvy_reg;

    logic [SAD_W-1:0]       min_sad_reg;
    logic [MV_W-1:0]        mv_x_reg, mv_y_reg;
    logic                   best_valid_reg, done_reg, early_hit_reg;
    logic [CNT_W-1:0]       beat_cnt_reg;

    logic accept, upd_en, improve, early_fire, drain_done, done_next;

    // Heap-ordered min tree: leaves NP-1.. hold lanes left to right, node 0 is the root.
    logic             node_ok  [NODES];
    logic [SAD_W-1:0] node_sad [NODES];
    logic [MV_W-1:0]  node_mvx [NODES];
    logic [MV_W-1:0]  node_mvy [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_leaf
            if (gi < LANES) begin : g_lane
                assign node_ok[NP-1+gi]  = s0_mask_reg[gi];
                assign node_sad[NP-1+gi] = s0_sad_reg[gi*SAD_W +: SAD_W];
                assign node_mvx[NP-1+gi] = s0_mvx_reg[gi*MV_W +: MV_W];
                assign node_mvy[NP-1+gi] = s0_mvy_reg[gi*MV_W +: MV_W];
            end else begin : g_pad
                assign node_ok[NP-1+gi]  = 1'b0;
                assign node_sad[NP-1+gi] = SAD_MAX;
                assign node_mvx[NP-1+gi] = '0;
                assign node_mvy[NP-1+gi] = '0;
            end
        end
        for (gi = 0; gi < NP - 1; gi++) begin : g_node
            logic take_left;
            // Left subtree holds lower lanes, so it wins ties.
            assign take_left    = node_ok[2*gi+1] &&
                                  (!node_ok[2*gi+2] || (node_sad[2*gi+1] <= node_sad[2*gi+2]));
            assign node_ok[gi]  = node_ok[2*gi+1] || node_ok[2*gi+2];
            assign node_sad[gi] = take_left ? node_sad[2*gi+1] : node_sad[2*gi+2];
            assign node_mvx[gi] = take_left ? node_mvx[2*gi+1] : node_mvx[2*gi+2];
            assign node_mvy[gi] = take_left ? node_mvy[2*gi+1] : node_mvy[2*gi+2];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        early_fire = 1'b0;
        accept     = bus.in_valid && (bus.start || (state_reg == RUN));
        upd_en     = !bus.start && s1_valid_reg && ((state_reg == RUN) || (state_reg == DRAIN));
        improve    = upd_en && s1_any_reg && (s1_sad_reg < min_sad_reg);
`ifdef SAD_EARLY_TERM_EN
        early_fire = improve && (state_reg == RUN) && (s1_sad_reg <= bus.thresh);
`endif
        drain_done = upd_en && s1_last_reg && (state_reg == DRAIN);
        done_next  = drain_done || early_fire;
        if (bus.start) begin
            state_next = (bus.in_valid && bus.in_last) ? DRAIN : RUN;
        end else begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                RUN: begin
                    if (early_fire)
                        state_next = HOLD;
                    else if (accept && bus.in_last)
                        state_next = DRAIN;
                end
                DRAIN:   if (drain_done) state_next = HOLD;
                HOLD:    state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

`ifndef SAD_EARLY_TERM_EN
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            s0_valid_reg   <= 1'b0;
            s1_valid_reg   <= 1'b0;
            min_sad_reg    <= SAD_MAX;
            mv_x_reg       <= '0;
            mv_y_reg       <= '0;
            best_valid_reg <= 1'b0;
            beat_cnt_reg   <= '0;
            done_reg       <= 1'b0;
            early_hit_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= done_next;
            s0_valid_reg <= accept;
            // start drops whatever is already past the input register
            s1_valid_reg <= s0_valid_reg && !bus.start;
            if (bus.start) begin
                min_sad_reg    <= SAD_MAX;
                best_valid_reg <= 1'b0;
                beat_cnt_reg   <= bus.in_valid ? CNT_W'(1) : '0;
                early_hit_reg  <= 1'b0;
            end else begin
                if (improve) begin
                    min_sad_reg <= s1_sad_reg;
                    mv_x_reg    <= s1_mvx_reg;
                    mv_y_reg    <= s1_mvy_reg;
                end
                if (upd_en && s1_any_reg)
                    best_valid_reg <= 1'b1;
                if (accept && (beat_cnt_reg != '1))
                    beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                if (early_fire)
                    early_hit_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        s0_last_reg <= bus.in_last;
        s0_mask_reg <= bus.lane_mask;
        s0_sad_reg  <= bus.sad_i;
        s0_mvx_reg  <= bus.mv_x_i;
        s0_mvy_reg  <= bus.mv_y_i;
        s1_last_reg <= s0_last_reg;
        s1_any_reg  <= node_ok[0];
        s1_sad_reg  <= node_sad[0];
        s1_mvx_reg  <= node_mvx[0];
        s1_mvy_reg  <= node_mvy[0];
    end

    assign bus.min_sad    = min_sad_reg;
    assign bus.mv_x       = mv_x_reg;
    assign bus.mv_y       = mv_y_reg;
    assign bus.best_valid = best_valid_reg;
    assign bus.beat_cnt   = beat_cnt_reg;
    assign bus.busy       = (state_reg == RUN) || (state_reg == DRAIN);
    assign bus.done       = done_reg;
    assign bus.early_hit  = early_hit_reg;
endmodule

// File: tb/tb_multi_sad_comparator.sv
// Directed and randomized bench for multi_sad_comparator with a per-search minimum model.
// Define SAD_EARLY_TERM_EN for both bench and design to exercise early termination.
module tb_multi_sad_comparator;
    localparam int SAD_W = 16;
    localparam int MV_W  = 6;
    localparam int LANES = 4;
    localparam int CNT_W = 12;
    localparam int SVB   = LANES * SAD_W;
    localparam int MVB   = LANES * MV_W;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [SAD_W-1:0] exp_min;
    logic [MV_W-1:0]  exp_mvx, exp_mvy;
    bit               exp_best, exp_has_mv;
    int               exp_cnt;
    logic [MVB-1:0]   cur_mvx, cur_mvy;

    multi_sad_comparator_if #(.SAD_W(SAD_W), .MV_W(MV_W), .LANES(LANES), .CNT_W(CNT_W)) sif ();

    multi_sad_comparator #(.SAD_W(SAD_W), .MV_W(MV_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [SVB-1:0] pk(input int a, input int b, input int c, input int d);
        return {SAD_W'(d), SAD_W'(c), SAD_W'(b), SAD_W'(a)};
    endfunction

    task automatic model_reset();
        exp_min    = '1;
        exp_best   = 1'b0;
        exp_cnt    = 0;
        exp_has_mv = 1'b0;
    endtask

    // Earlier beats and lower lanes are visited first, so strict < keeps the first minimum.
    task automatic model_apply(input logic [LANES-1:0] m, input logic [SVB-1:0] sv);
        logic [SAD_W-1:0] s;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                s = sv[l*SAD_W +: SAD_W];
                exp_best = 1'b1;
                if (s < exp_min) begin
                    exp_min    = s;
                    exp_mvx    = cur_mvx[l*MV_W +: MV_W];
                    exp_mvy    = cur_mvy[l*MV_W +: MV_W];
                    exp_has_mv = 1'b1;
                end
            end
        end
        exp_cnt++;
    endtask

    task automatic drive_beat(input logic [LANES-1:0] m, input logic [SVB-1:0] sv,
                              input bit last, input bit st, input bit acc);
        cur_mvx = MVB'($urandom);
        cur_mvy = MVB'($urandom);
        if (st) model_reset();
        if (acc) model_apply(m, sv);
        sif.start     = st;
        sif.in_valid  = 1'b1;
        sif.in_last   = last;
        sif.lane_mask = m;
        sif.sad_i     = sv;
        sif.mv_x_i    = cur_mvx;
        sif.mv_y_i    = cur_mvy;
        step();
        $display("beat mask=%b sad=%h last=%0d start=%0d -> min_sad=%h cnt=%0d",
                 m, sv, last, st, sif.min_sad, sif.beat_cnt);
        sif.start    = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic start_only();
        model_reset();
        sif.start = 1'b1;
        step();
        sif.start = 1'b0;
    endtask

    task automatic check_final(input string tag);
        chk($sformatf("%s.done", tag), 32'(sif.done), 32'd1);
        chk($sformatf("%s.min", tag), 32'(sif.min_sad), 32'(exp_min));
        chk($sformatf("%s.best", tag), 32'(sif.best_valid), 32'(exp_best));
        chk($sformatf("%s.cnt", tag), 32'(sif.beat_cnt), 32'(exp_cnt));
        chk($sformatf("%s.busy", tag), 32'(sif.busy), 32'd0);
        if (exp_has_mv) begin
            chk($sformatf("%s.mvx", tag), 32'(sif.mv_x), 32'(exp_mvx));
            chk($sformatf("%s.mvy", tag), 32'(sif.mv_y), 32'(exp_mvy));
        end
    endtask

    initial begin
        int nb;
        logic [LANES-1:0] m;
        logic [SVB-1:0] sv;
        rst           = 1'b1;
        sif.start     = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_last   = 1'b0;
        sif.lane_mask = '0;
        sif.sad_i     = '0;
        sif.mv_x_i    = '0;
        sif.mv_y_i    = '0;
        sif.thresh    = 16'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst.min", 32'(sif.min_sad), 32'hFFFF);
        chk("rst.mvx", 32'(sif.mv_x), 32'd0);
        chk("rst.best", 32'(sif.best_valid), 32'd0);
        chk("rst.busy", 32'(sif.busy), 32'd0);
        chk("rst.done", 32'(sif.done), 32'd0);
        chk("rst.cnt", 32'(sif.beat_cnt), 32'd0);
        chk("rst.early", 32'(sif.early_hit), 32'd0);

        // Single beat, lane tie 12/12 resolved to lane 1
        start_only();
        chk("s1.busy", 32'(sif.busy), 32'd1);
        drive_beat(4'b1111, pk(40, 12, 12, 90), 1'b1, 1'b0, 1'b1);
        step();
        chk("s1.done_early", 32'(sif.done), 32'd0);
        step();
        check_final("s1");
        step();
        chk("s1.pulse", 32'(sif.done), 32'd0);
        drive_beat(4'b1111, pk(1, 1, 1, 1), 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("s1.hold_min", 32'(sif.min_sad), 32'(exp_min));
        chk("s1.hold_cnt", 32'(sif.beat_cnt), 32'(exp_cnt));
        chk("s1.hold_done", 32'(sif.done), 32'd0);

        // Three beats, minima 30, 30, 25
        start_only();
        drive_beat(4'b1111, pk(30, 40, 50, 60), 1'b0, 1'b0, 1'b1);
        drive_beat(4'b1111, pk(70, 30, 80, 90), 1'b0, 1'b0, 1'b1);
        chk("s2.latency", 32'(sif.min_sad), 32'hFFFF);
        drive_beat(4'b1111, pk(25, 99, 99, 99), 1'b1, 1'b0, 1'b1);
        chk("s2.min_b1", 32'(sif.min_sad), 32'd30);
        step();
        chk("s2.tie_keep", 32'(sif.mv_x), 32'(dut.mv_x_reg));
        chk("s2.min_b2", 32'(sif.min_sad), 32'd30);
        step();
        check_final("s2");

        // Masked lanes, beat in the same cycle as start
        drive_beat(4'b0010, pk(5, 50, 1, 1), 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_final("s3");

        // All-masked final beat
        drive_beat(4'b0000, pk(3, 3, 3, 3), 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_final("s4");

        // All-ones SAD is a legal candidate
        drive_beat(4'b0001, pk(16'hFFFF, 0, 0, 0), 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_final("s5");

        // start while draining aborts; its own beat becomes the first of the new search
        start_only();
        drive_beat(4'b1111, pk(20, 21, 22, 23), 1'b1, 1'b0, 1'b1);
        drive_beat(4'b0001, pk(7, 0, 0, 0), 1'b0, 1'b1, 1'b1);
        chk("s6.min_clr", 32'(sif.min_sad), 32'hFFFF);
        chk("s6.busy", 32'(sif.busy), 32'd1);
        step();
        chk("s6.no_done", 32'(sif.done), 32'd0);
        chk("s6.min_flush", 32'(sif.min_sad), 32'hFFFF);
        step();
        chk("s6.min7", 32'(sif.min_sad), 32'd7);
        drive_beat(4'b0000, pk(0, 0, 0, 0), 1'b1, 1'b0, 1'b1);
        step();
        step();
        check_final("s6");

        // Threshold scenario: minima 50 then 18 with thresh 20
        sif.thresh = 16'd20;
        start_only();
        drive_beat(4'b1111, pk(50, 60, 70, 80), 1'b0, 1'b0, 1'b1);
        drive_beat(4'b1111, pk(90, 18, 40, 40), 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("s7.min18", 32'(sif.min_sad), 32'd18);
`ifdef SAD_EARLY_TERM_EN
        chk("s7.done", 32'(sif.done), 32'd1);
        chk("s7.early", 32'(sif.early_hit), 32'd1);
        chk("s7.busy", 32'(sif.busy), 32'd0);
        drive_beat(4'b1111, pk(3, 3, 3, 3), 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("s7.ignored_min", 32'(sif.min_sad), 32'd18);
        chk("s7.ignored_cnt", 32'(sif.beat_cnt), 32'(exp_cnt));
        chk("s7.early_hold", 32'(sif.early_hit), 32'd1);
`else
        chk("s7.done", 32'(sif.done), 32'd0);
        chk("s7.early", 32'(sif.early_hit), 32'd0);
        chk("s7.busy", 32'(sif.busy), 32'd1);
        drive_beat(4'b1111, pk(3, 30, 30, 30), 1'b1, 1'b0, 1'b1);
        step();
        step();
        check_final("s7");
        chk("s7.early_end", 32'(sif.early_hit), 32'd0);
`endif

        // Randomized searches; thresholds chosen so early termination never triggers
        for (int t = 0; t < 16; t++) begin
`ifdef SAD_EARLY_TERM_EN
            sif.thresh = 16'd0;
`else
            sif.thresh = 16'($urandom);
`endif
            nb = 1 + int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) start_only();
            for (int b = 0; b < nb; b++) begin
                m = 4'($urandom);
                sv = '0;
                for (int l = 0; l < LANES; l++)
                    sv[l*SAD_W +: SAD_W] = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                                                       : 16'(1 + $urandom_range(0, 40));
                drive_beat(m, sv, b == nb - 1, (b == 0) && !sif.busy, 1'b1);
                if ($urandom_range(0, 3) == 0 && b != nb - 1) step();
            end
            step();
            step();
            check_final($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d.early", t), 32'(sif.early_hit), 32'd0);
        end

        // Reset mid-search, asserted together with start
        start_only();
        drive_beat(4'b1111, pk(9, 9, 9, 9), 1'b0, 1'b0, 1'b1);
        drive_beat(4'b1111, pk(8, 8, 8, 8), 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        sif.start = 1'b1;
        step();
        rst = 1'b0;
        sif.start = 1'b0;
        chk("s8.busy", 32'(sif.busy), 32'd0);
        chk("s8.min", 32'(sif.min_sad), 32'hFFFF);
        chk("s8.cnt", 32'(sif.beat_cnt), 32'd0);
        chk("s8.best", 32'(sif.best_valid), 32'd0);
        drive_beat(4'b1111, pk(1, 1, 1, 1), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("s8.no_done%0d", k), 32'(sif.done), 32'd0);
        end
        chk("s8.idle_cnt", 32'(sif.beat_cnt), 32'd0);
        chk("s8.idle_min", 32'(sif.min_sad), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multi_sad_comparator.md
MULTI_SAD_COMPARATOR -- requirements
Module: multi_sad_comparator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SAD_W  16  SAD and minimum width, unsigned.
  MV_W  6  width of each motion-vector component.
  LANES  4  candidate SADs presented per beat, range 1..16.
  CNT_W  12  width of the accepted-beat counter.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock; one clock domain.
  rst  in  1  reset; synchronous, active-high.
  start  in  1  begins a new search and clears all search state.
  in_valid  in  1  beat qualifier; the block is always ready, with no backpressure.
  in_last  in  1  marks the final beat of a search; qualified by in_valid.
  lane_mask  in  LANES  per-lane enable; a masked lane never wins.
  sad_i  in  LANES*SAD_W  packed candidate SADs; lane 0 occupies the LSBs.
  mv_x_i  in  LANES*MV_W  packed candidate x vectors.
  mv_y_i  in  LANES*MV_W  packed candidate y vectors.
  thresh  in  SAD_W  early-termination threshold.
  min_sad  out  SAD_W  running and final minimum SAD.
  mv_x  out  MV_W  x vector of min_sad.
  mv_y  out  MV_W  y vector of min_sad.
  best_valid  out  1  set once any unmasked lane has been accepted.
  beat_cnt  out  CNT_W  beats accepted in the current search; saturates at all-ones.
  busy  out  1  high from start until done.
  done  out  1  one-cycle pulse when a search completes.
  early_hit  out  1  search terminated early by threshold.

Function
REQ-003 Stage 1 SHALL register the lane reduction tree: the minimum SAD over unmasked lanes, with its vector and an any-lane-valid flag.
REQ-004 Stage 2 SHALL update min_sad, mv_x and mv_y when the stage-1 result is valid and strictly less than min_sad.
REQ-005 Tie-break SHALL favour the lower lane index within a beat and the earlier beat across beats.
REQ-006 A beat with all lanes masked SHALL increment beat_cnt and leave min_sad, mv_x, mv_y and best_valid unchanged.
REQ-007 Latency SHALL be 2 cycles: a beat accepted at edge N is reflected in min_sad at edge N+2.
REQ-008 done SHALL pulse 2 cycles after the in_last beat is accepted, with final outputs valid in the same cycle.
REQ-009 The FSM SHALL have the states IDLE, RUN, DRAIN and HOLD.
  IDLE to RUN on start.
  RUN to DRAIN on an accepted in_last.
  DRAIN to HOLD after pipeline flush, pulsing done.
  HOLD to RUN on start.
REQ-010 In IDLE and HOLD, in_valid SHALL be ignored; in HOLD, outputs hold until the next start.
REQ-011 On start, min_sad SHALL be set to all-ones, best_valid to 0, beat_cnt to 0, early_hit to 0, and the stage-1 valid cleared.
REQ-012 A beat presented in the same cycle as start SHALL be accepted as the first beat of the new search.
REQ-013 start in any state, including RUN and DRAIN, SHALL abort the current search: no done pulse, and in-flight results are discarded.
REQ-014 A stage-1 SAD equal to all-ones SHALL be a legal candidate and SHALL set best_valid while leaving min_sad at all-ones.
REQ-015 in_last together with an all-masked beat SHALL still complete the search; best_valid=0 flags that no candidate was found.

Reset
REQ-016 rst SHALL set the following on the next edge and override start:
  FSM to IDLE.
  min_sad to all-ones.
  mv_x and mv_y to 0.
  best_valid, busy, done and early_hit to 0.
  beat_cnt to 0.
  stage-1 valid to 0.
REQ-017 rst asserted mid-search SHALL abandon the search without a done pulse.

Configuration
REQ-018 With SAD_EARLY_TERM_EN defined, when a stage-2 update makes min_sad <= thresh in RUN:
  early_hit is set.
  the FSM moves to HOLD with a done pulse on that cycle.
  later beats are ignored until start.
REQ-019 Without SAD_EARLY_TERM_EN, thresh SHALL be ignored and early_hit SHALL be tied to 0; all ports remain present.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  LANES=4. start, one beat with SADs {40,12,12,90}, mask 1111, in_last -> 2 cycles later done=1, min_sad=12, lane 1 vector, beat_cnt=1.
  Three beats with minima 30, 30, 25; last on beat 3 -> min_sad=25, vector from beat 3; the beat-2 tie does not replace beat 1.
  Mask 0010 with SADs {5,50,1,1} -> min_sad=50, lane 1 vector, best_valid=1.
  start asserted while DRAIN -> no done pulse, min_sad=FFFF; the same-cycle beat with SAD 7 yields min_sad=7 two cycles later.
  SAD_EARLY_TERM_EN defined, thresh=20, beats with minima 50 then 18 -> done and early_hit on the beat-2 update; a third beat with SAD 3 is ignored; min_sad=18.
  rst asserted mid-RUN -> next cycle IDLE, busy=0, min_sad=FFFF, and done never pulses.
